// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-line encodings, main-control opcodes,
// funct codes and the bundle carried from decode into execute.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned GIN_W   = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;

  typedef logic [GIN_W-1:0]   gin_t;
  typedef logic [ALUOP_W-1:0] aluop_t;
  typedef logic [FUNCT_W-1:0] funct_t;

  localparam gin_t GIN_AND = 3'b000;
  localparam gin_t GIN_OR  = 3'b001;
  localparam gin_t GIN_ADD = 3'b010;
  localparam gin_t GIN_SRL = 3'b011;
  localparam gin_t GIN_SUB = 3'b110;
  localparam gin_t GIN_SLT = 3'b111;

  localparam aluop_t ALUOP_MEM    = 2'b00;
  localparam aluop_t ALUOP_BRANCH = 2'b01;
  localparam aluop_t ALUOP_RTYPE  = 2'b10;
  localparam aluop_t ALUOP_RSVD   = 2'b11;

  localparam funct_t FUNCT_ADD = 6'b100000;
  localparam funct_t FUNCT_SUB = 6'b100010;
  localparam funct_t FUNCT_AND = 6'b100100;
  localparam funct_t FUNCT_OR  = 6'b100101;
  localparam funct_t FUNCT_SLT = 6'b101010;
  localparam funct_t FUNCT_SRL = 6'b000010;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    gin_t              gin;
    logic              illegal;
    logic [REG_W-1:0]  shamt;
    logic [REG_W-1:0]  rd;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUNDLE_RST = '{
    a:       '0,
    b:       '0,
    gin:     GIN_ADD,
    illegal: 1'b0,
    shamt:   '0,
    rd:      '0
  };

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU control decode from main-control opcode and funct field.
// Unsupported combinations fall back to ADD and raise illegal.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [GIN_W-1:0]   gin,
  output logic               illegal
);

  always_comb begin
    gin     = GIN_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:    gin = GIN_ADD;
      ALUOP_BRANCH: gin = GIN_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: gin = GIN_ADD;
          FUNCT_SUB: gin = GIN_SUB;
          FUNCT_AND: gin = GIN_AND;
          FUNCT_OR:  gin = GIN_OR;
          FUNCT_SLT: gin = GIN_SLT;
          FUNCT_SRL: gin = GIN_SRL;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline stage: decodes ALU control, selects operand B and
// buffers bundles in a 2-entry skid buffer so in_ready depends only on registers.
module id_ex_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_alusrc,
  input  logic [REG_W-1:0]   in_shamt,
  input  logic [REG_W-1:0]   in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [GIN_W-1:0]   out_gin,
  output logic [REG_W-1:0]   out_shamt,
  output logic [REG_W-1:0]   out_rd,
  output logic               out_illegal
);

  ex_bundle_t r_main;
  ex_bundle_t r_skid;
  logic       r_main_valid;
  logic       r_skid_valid;

  ex_bundle_t w_main_nxt;
  ex_bundle_t w_skid_nxt;
  logic       w_main_valid_nxt;
  logic       w_skid_valid_nxt;

  ex_bundle_t w_in_bundle;
  gin_t       w_gin;
  logic       w_illegal;
  logic       w_accept;
  logic       w_consume;

  alu_ctrl u_alu_ctrl (
    .aluop   (in_aluop),
    .funct   (in_funct),
    .gin     (w_gin),
    .illegal (w_illegal)
  );

  always_comb begin
    w_in_bundle.a       = in_rs_data;
    w_in_bundle.b       = in_alusrc ? in_imm : in_rt_data;
    w_in_bundle.gin     = w_gin;
    w_in_bundle.illegal = w_illegal;
    w_in_bundle.shamt   = in_shamt;
    w_in_bundle.rd      = in_rd;
  end

  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_consume = r_main_valid & out_ready;

  // Skid refills main first, so the main register never empties while skid holds data.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_consume) begin
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_nxt       = w_in_bundle;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_in_bundle;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main       <= EX_BUNDLE_RST;
      r_skid       <= EX_BUNDLE_RST;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  assign out_valid   = r_main_valid;
  assign out_a       = r_main.a;
  assign out_b       = r_main.b;
  assign out_gin     = r_main.gin;
  assign out_shamt   = r_main.shamt;
  assign out_rd      = r_main.rd;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: decode table, operand mux,
// skid-buffer ordering and stall hold, flush and reset behaviour.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [31:0] in_imm;
  logic        in_alusrc;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_gin;
  logic [4:0]  out_shamt;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_pass  = 0;
  int n_total = 0;

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct    (in_funct),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .in_imm      (in_imm),
    .in_alusrc   (in_alusrc),
    .in_shamt    (in_shamt),
    .in_rd       (in_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_gin     (out_gin),
    .out_shamt   (out_shamt),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic src, input logic [4:0] sh, input logic [4:0] rd);
    in_valid   = v;
    in_aluop   = op;
    in_funct   = fn;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm     = imm;
    in_alusrc  = src;
    in_shamt   = sh;
    in_rd      = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b101010, 32'hDEAD, 32'hBEEF, 32'h1, 1'b0, 5'd3, 5'd9);
    tick();
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_a !== 32'h0 || out_b !== 32'h0) $display("FAIL rst_operands: got a=%h b=%h want 0/0", out_a, out_b); else n_pass++;
    n_total++; if (out_gin !== 3'b010) $display("FAIL rst_gin: got %b want 010", out_gin); else n_pass++;
    n_total++; if (out_shamt !== 5'd0 || out_rd !== 5'd0 || out_illegal !== 1'b0)
      $display("FAIL rst_fields: got shamt=%0d rd=%0d ill=%b want 0/0/0", out_shamt, out_rd, out_illegal); else n_pass++;
    reset = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_gin !== 3'b010)
      $display("FAIL idle: got valid=%b ready=%b gin=%b want 0/1/010", out_valid, in_ready, out_gin); else n_pass++;
  endtask

  task automatic test_rtype();
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 6'b101010, 32'd5, 32'd7, 32'h1234, 1'b0, 5'd4, 5'd12);
    tick();
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL rtype_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_gin !== 3'b111) $display("FAIL rtype_gin: got %b want 111", out_gin); else n_pass++;
    n_total++; if (out_a !== 32'd5 || out_b !== 32'd7) $display("FAIL rtype_ops: got a=%0d b=%0d want 5/7", out_a, out_b); else n_pass++;
    n_total++; if (out_shamt !== 5'd4 || out_rd !== 5'd12 || out_illegal !== 1'b0)
      $display("FAIL rtype_fields: got shamt=%0d rd=%0d ill=%b want 4/12/0", out_shamt, out_rd, out_illegal); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rtype_drain: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 6'b100101, 32'd100, 32'd123, 32'hFFFFFFFC, 1'b1, 5'd0, 5'd8);
    tick();
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    n_total++; if (out_valid !== 1'b1 || out_gin !== 3'b010 || out_illegal !== 1'b0)
      $display("FAIL lw_ctrl: got valid=%b gin=%b ill=%b want 1/010/0", out_valid, out_gin, out_illegal); else n_pass++;
    n_total++; if (out_a !== 32'd100 || out_b !== 32'hFFFFFFFC)
      $display("FAIL lw_ops: got a=%h b=%h want 00000064/fffffffc", out_a, out_b); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", in_ready); else n_pass++;
    drive(1'b1, 2'b10, 6'b100000, 32'hA0, 32'hA1, 32'h0, 1'b0, 5'd1, 5'd1);
    tick();
    n_total++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || in_ready !== 1'b1)
      $display("FAIL b2b_first: got valid=%b rd=%0d ready=%b want 1/1/1", out_valid, out_rd, in_ready); else n_pass++;
    drive(1'b1, 2'b10, 6'b100010, 32'hB0, 32'hB1, 32'h0, 1'b0, 5'd2, 5'd2);
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_a !== 32'hA0 || out_b !== 32'hA1 || out_gin !== 3'b010 || out_rd !== 5'd1)
      $display("FAIL b2b_hold1: got a=%h b=%h gin=%b rd=%0d want a0/a1/010/1", out_a, out_b, out_gin, out_rd); else n_pass++;
    drive(1'b1, 2'b10, 6'b100100, 32'hC0, 32'hC1, 32'h0, 1'b0, 5'd3, 5'd3);
    tick();
    n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL b2b_stall: got ready=%b valid=%b want 0/1", in_ready, out_valid); else n_pass++;
    n_total++; if (out_a !== 32'hA0 || out_b !== 32'hA1 || out_shamt !== 5'd1 || out_rd !== 5'd1)
      $display("FAIL b2b_hold2: got a=%h b=%h sh=%0d rd=%0d want a0/a1/1/1", out_a, out_b, out_shamt, out_rd); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_a !== 32'hB0 || out_gin !== 3'b110 || out_rd !== 5'd2)
      $display("FAIL b2b_second: got valid=%b a=%h gin=%b rd=%0d want 1/b0/110/2", out_valid, out_a, out_gin, out_rd); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_skid_drained: got %b want 1", in_ready); else n_pass++;
    tick();
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    n_total++; if (out_valid !== 1'b1 || out_a !== 32'hC0 || out_b !== 32'hC1 || out_gin !== 3'b000 || out_rd !== 5'd3)
      $display("FAIL b2b_third: got valid=%b a=%h b=%h gin=%b rd=%0d want 1/c0/c1/000/3", out_valid, out_a, out_b, out_gin, out_rd); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_swap_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 6'b0, 32'h11, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4);
    tick();
    drive(1'b1, 2'b00, 6'b0, 32'h22, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5);
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full: got %b want 0", in_ready); else n_pass++;
    flush = 1'b1;
    drive(1'b1, 2'b00, 6'b0, 32'h33, 32'h0, 32'h0, 1'b0, 5'd0, 5'd6);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_full: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_full_nodeliver: got %b want 0", out_valid); else n_pass++;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 6'b0, 32'h44, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7);
    tick();
    n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_rd !== 5'd7)
      $display("FAIL flush_pre_main: got valid=%b ready=%b rd=%0d want 1/1/7", out_valid, in_ready, out_rd); else n_pass++;
    flush = 1'b1;
    drive(1'b1, 2'b01, 6'b0, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_accept: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_accept_nodeliver: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_decode();
    logic [1:0] ops   [12] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [5:0] fns   [12] = '{6'b100010, 6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b101010, 6'b000010, 6'b000000, 6'b100000, 6'b101010, 6'b111111};
    logic [2:0] gins  [12] = '{3'b010, 3'b110, 3'b010, 3'b110, 3'b000, 3'b001,
                               3'b111, 3'b011, 3'b010, 3'b010, 3'b010, 3'b010};
    logic       ills  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ops[i], fns[i], 32'(i), 32'(i + 100), 32'h0, 1'b0, 5'd0, 5'(i));
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_gin !== gins[i] || out_illegal !== ills[i] || out_rd !== 5'(i))
        $display("FAIL decode_%0d: got valid=%b gin=%b ill=%b rd=%0d want 1/%b/%b/%0d",
                 i, out_valid, out_gin, out_illegal, out_rd, gins[i], ills[i], i);
      else n_pass++;
    end
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b100000, 32'h77, 32'h78, 32'h0, 1'b0, 5'd2, 5'd10);
    tick();
    drive(1'b1, 2'b10, 6'b100000, 32'h88, 32'h89, 32'h0, 1'b0, 5'd2, 5'd11);
    tick();
    reset = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_a !== 32'h0 || out_rd !== 5'd0 || out_gin !== 3'b010)
      $display("FAIL midreset: got valid=%b ready=%b a=%h rd=%0d gin=%b want 0/1/0/0/010",
               out_valid, in_ready, out_a, out_rd, out_gin); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL midreset_drained: got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    reset = 1'b1;
    test_reset();
    test_rtype();
    test_lw();
    test_back_to_back();
    test_flush();
    test_decode();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
